// File: rtl/worley_point_scheduler_if.sv
// Handshake bundle between the frame timing source and the point scheduler.
// The master side drives the frame controls. The slave side is the scheduler,
// which publishes the committed point set and its status flags.
interface worley_point_scheduler_if #(
  parameter int NUM_PTS = 4,
  parameter int COORD_W = 10
);
  logic                       frame_start;
  logic                       pause;
  logic [1:0]                 speed;
  logic [NUM_PTS*COORD_W-1:0] pts_x;
  logic [NUM_PTS*COORD_W-1:0] pts_y;
  logic                       busy;
  logic                       update_done;
  logic                       overrun;
  logic [19:0]                frame_count;

  modport master (
    output frame_start, pause, speed,
    input  pts_x, pts_y, busy, update_done, overrun, frame_count
  );

  modport slave (
    input  frame_start, pause, speed,
    output pts_x, pts_y, busy, update_done, overrun, frame_count
  );
endinterface

// File: rtl/worley_point_scheduler.sv
// Worley feature-point scheduler.
// Once every FRAME_DIV frame_starts, each point moves by its velocity. The
// points are updated one per cycle into shadow registers. The whole set is
// then published on a single commit edge, so the pixel datapath never sees
// a mix of old and new positions.
// Macro WORLEY_BOUNCE_EN: points reflect off the edges and their velocity
// reverses. When it is undefined, points wrap around to the opposite edge.
module worley_point_scheduler #(
  parameter int NUM_PTS   = 4,
  parameter int COORD_W   = 10,
  parameter int H_MAX     = 639,
  parameter int V_MAX     = 479,
  parameter int FRAME_DIV = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  worley_point_scheduler_if.slave bus
);
  localparam int AW = COORD_W + 3;
  localparam int IW = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
  localparam logic signed [AW-1:0] LX = AW'(H_MAX);
  localparam logic signed [AW-1:0] LY = AW'(V_MAX);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;
  typedef struct packed {
    logic [3:0]         v;
    logic [COORD_W-1:0] p;
  } step_t;

  state_t                           state, state_nxt;
  logic [NUM_PTS-1:0][COORD_W-1:0]  px, py, sx, sy;
  logic [NUM_PTS-1:0][3:0]          vx, vy;
  logic [IW-1:0]                    idx;
  logic [1:0]                       spd;
  logic [7:0]                       div_cnt;
  logic [19:0]                      frame_cnt;
  logic                             ovr;
  logic                             div_hit;
  step_t                            ux, uy;

  function automatic logic [COORD_W-1:0] rst_x(input int i);
    case (i % 4)
      0: return COORD_W'(100);
      1: return COORD_W'(300);
      2: return COORD_W'(500);
      default: return COORD_W'(100);
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] rst_y(input int i);
    case (i % 4)
      0: return COORD_W'(100);
      1: return COORD_W'(200);
      2: return COORD_W'(400);
      default: return COORD_W'(300);
    endcase
  endfunction

  // Velocities are stored as 4-bit two's complement values.
  function automatic logic [3:0] rst_vx(input int i);
    case (i % 4)
      0: return 4'h2;
      1: return 4'hF;
      2: return 4'h1;
      default: return 4'hD;
    endcase
  endfunction

  function automatic logic [3:0] rst_vy(input int i);
    case (i % 4)
      0: return 4'hE;
      1: return 4'h1;
      2: return 4'hF;
      default: return 4'h3;
    endcase
  endfunction

  // Advance one axis. The sum is signed and wide enough that the edge
  // overshoot stays visible before it is folded back into range.
  function automatic step_t step(input logic [COORD_W-1:0] p, input logic [3:0] v,
                                 input logic [1:0] s, input logic signed [AW-1:0] lim);
    logic signed [AW-1:0] dv;
    logic signed [AW-1:0] n;
    step_t r;
    dv  = AW'($signed(v));
    dv  = dv <<< s;
    n   = $signed({3'b000, p}) + dv;
    r.v = v;
    r.p = n[COORD_W-1:0];
`ifdef WORLEY_BOUNCE_EN
    if (n < 0) begin
      r.p = COORD_W'(-n);
      r.v = -v;
    end else if (n > lim) begin
      r.p = COORD_W'(lim + lim - n);
      r.v = -v;
    end
`else
    if (n < 0)
      r.p = COORD_W'(n + lim + AW'(1));
    else if (n > lim)
      r.p = COORD_W'(n - lim - AW'(1));
`endif
    return r;
  endfunction

  assign div_hit = ({1'b0, div_cnt} + 9'd1) == 9'(FRAME_DIV);
  assign ux      = step(sx[idx], vx[idx], spd, LX);
  assign uy      = step(sy[idx], vy[idx], spd, LY);

  assign bus.pts_x       = px;
  assign bus.pts_y       = py;
  assign bus.busy        = (state != IDLE);
  assign bus.update_done = (state == COMMIT);
  assign bus.overrun     = ovr;
  assign bus.frame_count = frame_cnt;

  // Sequence control: IDLE waits for a divided frame, UPDATE walks the
  // points, and COMMIT publishes the set.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.frame_start && div_hit && !bus.pause) state_nxt = UPDATE;
      UPDATE:  if (idx == IW'(NUM_PTS - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, shadow updates and the commit. Reset clears all of
  // these at once, so a sequence cut short by reset publishes nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      spd       <= '0;
      div_cnt   <= '0;
      frame_cnt <= '0;
      ovr       <= 1'b0;
      for (int i = 0; i < NUM_PTS; i++) begin
        px[i] <= rst_x(i);
        sx[i] <= rst_x(i);
        py[i] <= rst_y(i);
        sy[i] <= rst_y(i);
        vx[i] <= rst_vx(i);
        vy[i] <= rst_vy(i);
      end
    end else begin
      state <= state_nxt;
      if (bus.frame_start) frame_cnt <= frame_cnt + 20'd1;
      if (bus.frame_start && state != IDLE) ovr <= 1'b1;
      if (bus.frame_start && state == IDLE) div_cnt <= div_hit ? 8'd0 : div_cnt + 8'd1;
      if (state == IDLE) begin
        idx <= '0;
        spd <= (bus.speed == 2'd3) ? 2'd2 : bus.speed;
      end
      if (state == UPDATE) begin
        sx[idx] <= ux.p;
        vx[idx] <= ux.v;
        sy[idx] <= uy.p;
        vy[idx] <= uy.v;
        idx     <= idx + IW'(1);
      end
      if (state == COMMIT) begin
        px <= sx;
        py <= sy;
      end
    end
  end
endmodule
